product_accum: RTL and testbench
================================

PRODUCT_ACCUM -- requirements
Module: product_accum

Interface
REQ-001 Parameter WIDTH, default 4: operand width of the upstream multiplier; each product is 2*WIDTH bits.
REQ-002 Parameter BATCH, default 4: number of products summed per output; power of two, >= 2.
REQ-003 Parameter FIFO_DEPTH, default 2: number of entries in the skid FIFO.
REQ-004 Local ACC_W = 2*WIDTH + log2(BATCH), which is 10 at defaults; CNT_W = log2(BATCH) + 1, which is 3 at defaults.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 in_valid  input  1  product valid pulse from the buffered multiplier; no backpressure exists toward the producer.
REQ-008 in_data  input  2*WIDTH  unsigned product; sampled only when in_valid=1.
REQ-009 flush  input  1  request to emit a partial batch.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_valid  output  1  registered flag: a result is held.
REQ-012 out_data  output  ACC_W  unsigned batch sum.
REQ-013 out_cnt  output  CNT_W  number of products in out_data, in the range 1..BATCH.
REQ-014 out_drop  output  1  sticky flag: a product was lost.

Function
REQ-015 The FSM SHALL have two states, ACCUM and HOLD, and SHALL reset to ACCUM.
REQ-016 ACCUM, operand source:
- If the FIFO is non-empty, pop the head entry and add it to acc.
- Otherwise, if in_valid=1, add in_data directly to acc.
- Adding a product increments cnt by 1.
REQ-017 ACCUM, incoming product while the FIFO is non-empty: push in_data into the FIFO; a push into a full FIFO is legal when a pop happens in the same cycle.
REQ-018 ACCUM, batch complete: when an add makes cnt equal BATCH, on the next edge:
- out_data <= acc + added value;
- out_cnt <= BATCH;
- out_valid <= 1;
- acc <= 0, cnt <= 0;
- state <= HOLD.
REQ-019 Latency from the edge that samples the BATCH-th product to out_valid=1 SHALL be exactly 1 cycle, independent of data values.
REQ-020 ACCUM, flush=1 with cnt, or cnt plus this cycle's add, greater than 0: emit as in REQ-018 with out_cnt = the resulting count, and include this cycle's add.
REQ-021 ACCUM, flush=1 with resulting count 0: the block SHALL ignore flush.
REQ-022 HOLD: out_valid=1; out_data and out_cnt stay stable until the handshake (out_valid & out_ready).
REQ-023 HOLD, handshake: on the handshake edge, out_valid <= 0 and state <= ACCUM; out_data and out_cnt hold their last values afterwards.
REQ-024 HOLD: the block SHALL ignore flush.
REQ-025 HOLD, incoming products:
- in_valid=1 pushes into the FIFO, including on the handshake cycle.
- If the FIFO is full, the product is discarded and out_drop <= 1.
REQ-026 out_drop SHALL clear only on rst.
REQ-027 No arithmetic overflow is possible, because BATCH * (2^WIDTH - 1)^2 < 2^ACC_W; no saturation logic is required.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the FIFO SHALL track a count in the range 0..FIFO_DEPTH.

Reset
REQ-029 When rst=1 at an edge, the block SHALL set:
- state = ACCUM;
- acc = 0, cnt = 0;
- FIFO count and pointers = 0;
- out_valid = 0, out_data = 0, out_cnt = 0, out_drop = 0.
REQ-030 rst SHALL take priority over all other inputs, including mid-HOLD and mid-batch; any held result and FIFO contents are discarded.
REQ-031 The block SHALL ignore in_valid in the cycle rst=1.

Verification
REQ-032 Full batch:
- Stimulus: products 3, 5, 0, 225 on consecutive cycles.
- Required: out_valid=1 one cycle after 225 is sampled, with out_data=233 and out_cnt=4.
REQ-033 Skid FIFO:
- Stimulus: HOLD with out_ready=0; products 7 then 9 arrive; out_ready=1 for one cycle.
- Required: both products drain in the next 2 cycles with no loss; cnt=2 and acc=16 at the end.
REQ-034 Drop:
- Stimulus: HOLD with the FIFO full (7, 9); product 11 arrives.
- Required: 11 is discarded and out_drop=1 persists; FIFO contents are unchanged.
REQ-035 Partial flush:
- Stimulus: products 10, 20; then flush=1 with in_valid=0.
- Required: out_data=30 and out_cnt=2 next cycle.
- Stimulus: flush=1 with cnt=0 and the FIFO empty.
- Required: no output.
REQ-036 Simultaneous events:
- Stimulus: handshake and in_valid (value 4) in the same cycle.
- Required: 4 enters the FIFO and is summed in the following ACCUM cycle.
- Stimulus: flush with in_valid (value 6) at cnt=1, acc=2.
- Required: out_data=8 and out_cnt=2.
REQ-037 Reset mid-operation:
- Stimulus: rst=1 while in HOLD with the FIFO holding 2 entries.
- Required: the next cycle shows all outputs 0 and ACCUM state; the next 4 products form a clean batch.

Source files
------------

// File: rtl/product_accum.sv
// Batch accumulator for multiplier products with a small skid FIFO.
// Emits one sum per BATCH products, or a partial sum on flush.
module product_accum #(
   parameter int WIDTH      = 4,
   parameter int BATCH      = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   input  logic [2*WIDTH-1:0]               in_data,
   input  logic                             flush,
   input  logic                             out_ready,
   output logic                             out_valid,
   output logic [2*WIDTH+$clog2(BATCH)-1:0] out_data,
   output logic [$clog2(BATCH):0]           out_cnt,
   output logic                             out_drop
);

   localparam int PW    = 2 * WIDTH;
   localparam int ACC_W = PW + $clog2(BATCH);
   localparam int CNT_W = $clog2(BATCH) + 1;
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCW   = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {S_ACCUM, S_HOLD} state_t;

   state_t             r_state;
   state_t             w_state_nx;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [PW-1:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]      r_wp;
   logic [AW-1:0]      r_rp;
   logic [FCW-1:0]     r_fcnt;
   logic               r_valid;
   logic [ACC_W-1:0]   r_odata;
   logic [CNT_W-1:0]   r_ocnt;
   logic               r_drop;

   logic               w_ne;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_emit;
   logic               w_hs;
   logic [PW-1:0]      w_add_val;
   logic               w_add_en;
   logic [CNT_W-1:0]   w_cnt_nx;
   logic [ACC_W-1:0]   w_sum;

   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_ne   = (r_fcnt != '0);
   assign w_full = (r_fcnt == FCW'(FIFO_DEPTH));

   always_comb begin
      w_state_nx = r_state;
      w_pop      = 1'b0;
      w_push     = 1'b0;
      w_drop     = 1'b0;
      w_emit     = 1'b0;
      w_hs       = 1'b0;
      w_add_en   = 1'b0;
      w_add_val  = '0;
      w_cnt_nx   = r_cnt;
      w_sum      = r_acc;
      unique case (r_state)
         S_ACCUM: begin
            // Buffered products always go first to keep arrival order
            if (w_ne) begin
               w_pop     = 1'b1;
               w_add_en  = 1'b1;
               w_add_val = r_mem[r_rp];
               w_push    = in_valid;
            end else if (in_valid) begin
               w_add_en  = 1'b1;
               w_add_val = in_data;
            end
            w_cnt_nx = r_cnt + CNT_W'(w_add_en);
            w_sum    = r_acc + ACC_W'(w_add_val);
            w_emit   = (w_cnt_nx == CNT_W'(BATCH)) ||
                       (flush && (w_cnt_nx != '0));
            if (w_emit) w_state_nx = S_HOLD;
         end
         S_HOLD: begin
            w_hs = out_ready;
            if (in_valid) begin
               if (w_full) w_drop = 1'b1;
               else        w_push = 1'b1;
            end
            if (w_hs) w_state_nx = S_ACCUM;
         end
         default: w_state_nx = S_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_ACCUM;
      else     r_state <= w_state_nx;
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_fcnt  <= '0;
         r_valid <= 1'b0;
         r_odata <= '0;
         r_ocnt  <= '0;
         r_drop  <= 1'b0;
      end else begin
         if (w_push) r_wp <= f_inc(r_wp);
         if (w_pop)  r_rp <= f_inc(r_rp);
         unique case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + FCW'(1);
            2'b01:   r_fcnt <= r_fcnt - FCW'(1);
            default: r_fcnt <= r_fcnt;
         endcase
         if (w_drop) r_drop <= 1'b1;
         if (r_state == S_ACCUM) begin
            if (w_emit) begin
               r_odata <= w_sum;
               r_ocnt  <= w_cnt_nx;
               r_valid <= 1'b1;
               r_acc   <= '0;
               r_cnt   <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= w_cnt_nx;
            end
         end else if (w_hs) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_odata;
   assign out_cnt   = r_ocnt;
   assign out_drop  = r_drop;

endmodule

// File: tb/tb_product_accum.sv
// Directed vector bench for product_accum at default parameters.
// Table rows are one clock each; outputs are checked 1ns after the edge.
module tb_product_accum;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       flush;
   logic       out_ready;
   logic       out_valid;
   logic [9:0] out_data;
   logic [2:0] out_cnt;
   logic       out_drop;

   int n_checks = 0;
   int n_errors = 0;

   product_accum dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .flush     (flush),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_cnt   (out_cnt),
      .out_drop  (out_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       iv;
      logic [7:0] d;
      logic       fl;
      logic       rdy;
      logic       ev;
      logic [9:0] ed;
      logic [2:0] ec;
      logic       edr;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, iv, input logic [7:0] d,
                      input logic fl, rdy, ev, input logic [9:0] ed,
                      input logic [2:0] ec, input logic edr);
      vec_t v;
      v.r = r; v.iv = iv; v.d = d; v.fl = fl; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.ec = ec; v.edr = edr;
      tv.push_back(v);
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step(input logic r, iv, input logic [7:0] d,
                       input logic fl, rdy);
      rst = r; in_valid = iv; in_data = d; flush = fl; out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic ev,
                            input int ed, input int ec, input logic edr);
      check({tag, ".valid"}, int'(out_valid), int'(ev));
      check({tag, ".data"},  int'(out_data),  ed);
      check({tag, ".cnt"},   int'(out_cnt),   ec);
      check({tag, ".drop"},  int'(out_drop),  int'(edr));
   endtask

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      flush = 1'b0; out_ready = 1'b0;

      //  r  iv d    fl rdy  ev  data cnt drop
      add(1, 0, 0,   0, 0,   0,   0, 0, 0);   // 0 reset
      add(1, 1, 99,  0, 0,   0,   0, 0, 0);   // 1 in_valid ignored in reset
      add(0, 1, 3,   0, 0,   0,   0, 0, 0);   // 2 full batch
      add(0, 1, 5,   0, 0,   0,   0, 0, 0);
      add(0, 1, 0,   0, 0,   0,   0, 0, 0);
      add(0, 1, 225, 0, 0,   1, 233, 4, 0);   // 5 latency 1
      add(0, 1, 7,   0, 0,   1, 233, 4, 0);   // 6 skid
      add(0, 1, 9,   0, 0,   1, 233, 4, 0);   // 7 fifo full
      add(0, 1, 11,  0, 0,   1, 233, 4, 1);   // 8 drop
      add(0, 0, 0,   1, 0,   1, 233, 4, 1);   // 9 flush ignored in hold
      add(0, 0, 0,   0, 1,   0, 233, 4, 1);   // 10 handshake
      add(0, 0, 0,   0, 0,   0, 233, 4, 1);   // 11 pop 7
      add(0, 0, 0,   0, 0,   0, 233, 4, 1);   // 12 pop 9
      add(0, 0, 0,   1, 0,   1,  16, 2, 1);   // 13 11 not in fifo
      add(0, 1, 4,   0, 1,   0,  16, 2, 1);   // 14 handshake + push 4
      add(0, 1, 5,   0, 0,   0,  16, 2, 1);   // 15 pop 4, push 5
      add(0, 0, 0,   1, 0,   1,   9, 2, 1);   // 16 pop 5 + flush
      add(0, 0, 0,   0, 1,   0,   9, 2, 1);
      add(0, 1, 10,  0, 0,   0,   9, 2, 1);   // 18 partial flush
      add(0, 1, 20,  0, 0,   0,   9, 2, 1);
      add(0, 0, 0,   1, 0,   1,  30, 2, 1);
      add(0, 0, 0,   0, 1,   0,  30, 2, 1);
      add(0, 0, 0,   1, 0,   0,  30, 2, 1);   // 22 empty flush ignored
      add(0, 0, 0,   0, 0,   0,  30, 2, 1);
      add(0, 1, 2,   0, 0,   0,  30, 2, 1);   // 24 acc=2 cnt=1
      add(0, 1, 6,   1, 0,   1,   8, 2, 1);   // 25 flush with add
      add(0, 0, 0,   0, 1,   0,   8, 2, 1);
      add(0, 1, 15,  1, 0,   1,  15, 1, 1);   // 27 flush from cnt 0
      add(0, 0, 0,   0, 1,   0,  15, 1, 1);
      add(0, 1, 1,   0, 0,   0,  15, 1, 1);   // 29 batch then reset
      add(0, 1, 2,   0, 0,   0,  15, 1, 1);
      add(0, 1, 3,   0, 0,   0,  15, 1, 1);
      add(0, 1, 4,   0, 0,   1,  10, 4, 1);
      add(0, 1, 50,  0, 0,   1,  10, 4, 1);
      add(0, 1, 60,  0, 0,   1,  10, 4, 1);
      add(1, 1, 70,  0, 1,   0,   0, 0, 0);   // 35 reset mid-hold
      add(0, 1, 225, 0, 0,   0,   0, 0, 0);   // 36 max products
      add(0, 1, 225, 0, 0,   0,   0, 0, 0);
      add(0, 1, 225, 0, 0,   0,   0, 0, 0);
      add(0, 1, 225, 0, 0,   1, 900, 4, 0);
      add(0, 0, 0,   0, 1,   0, 900, 4, 0);

      foreach (tv[i]) begin
         step(tv[i].r, tv[i].iv, tv[i].d, tv[i].fl, tv[i].rdy);
         check_out($sformatf("vec%0d", i), tv[i].ev, int'(tv[i].ed),
                   int'(tv[i].ec), tv[i].edr);
      end

      // Latency and stability under backpressure
      step(0, 1, 1, 0, 0);
      step(0, 1, 2, 0, 0);
      step(0, 1, 3, 0, 0);
      step(0, 1, 4, 0, 0);
      lat = 1;
      while (!out_valid && lat < 10) begin
         step(0, 0, 0, 0, 0);
         lat++;
      end
      check("latency", lat, 1);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 1, 0);
         check_out($sformatf("stall%0d", k), 1'b1, 10, 4, 1'b0);
      end

      // Handshake with full fifo and a third arrival
      step(0, 1, 100, 0, 0);
      step(0, 1, 101, 0, 0);
      check_out("full_hold", 1'b1, 10, 4, 1'b0);
      step(0, 1, 102, 0, 1);
      check_out("hs_drop", 1'b0, 10, 4, 1'b1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 5, 0, 0);
      check_out("drain_mid", 1'b0, 10, 4, 1'b1);
      step(0, 1, 6, 0, 0);
      check_out("drain_batch", 1'b1, 212, 4, 1'b1);
      step(0, 0, 0, 0, 1);
      check_out("final_hs", 1'b0, 212, 4, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
